regfile_param_dbg: RTL and testbench
====================================

// Module: regfile_param_dbg
// PURPOSE
//  Parametrised CPU general-purpose register file: 2 async read ports, 1 sync write port.
//  Adds a handshaked IO-injection write port that is gated by a lock register.
//  Adds a sequential dump engine that streams a register window, one register per cycle,
//  to the board display/debug logic. Sits in the CPU datapath between decode and writeback.
// PARAMETERS
//  DATA_W      32  register width in bits
//  ADDR_W      5   address width; depth = 2**ADDR_W; reg 0 hardwired to zero
//  DUMP_FIRST  3   first register index streamed by the dump engine
//  DUMP_LAST   10  last register index streamed; DUMP_FIRST <= DUMP_LAST < 2**ADDR_W
//  LOCK_REG    31  register whose nonzero value blocks IO injection
// PORTS
//  clk         in   1       rising-edge clock; all state updates on posedge
//  rst         in   1       reset, asynchronous, active-high
//  we          in   1       CPU write enable
//  waddr       in   ADDR_W  CPU write address
//  wdata       in   DATA_W  CPU write data
//  raddr1      in   ADDR_W  read port 1 address
//  raddr2      in   ADDR_W  read port 2 address
//  rdata1      out  DATA_W  read port 1 data (combinational)
//  rdata2      out  DATA_W  read port 2 data (combinational)
//  io_valid    in   1       IO injection request
//  io_addr     in   ADDR_W  IO injection address
//  io_data     in   DATA_W  IO injection data
//  io_ready    out  1       IO injection accepted this cycle (combinational)
//  dump_start  in   1       1-cycle pulse: start a dump sweep
//  dump_busy   out  1       dump engine in RUN
//  dump_valid  out  1       dump_addr/dump_data valid this cycle
//  dump_addr   out  ADDR_W  index of the streamed register
//  dump_data   out  DATA_W  contents of the streamed register
//  dump_done   out  1       1-cycle pulse after the last beat
// BEHAVIOUR
//  - Reset: all registers 0; FSM IDLE; dump_busy/valid/done, dump_addr, dump_data = 0.
//    Reset mid-dump aborts the sweep with no dump_done pulse.
//  - Reg 0 reads 0 always; writes to addr 0 from either port are dropped. Dropped IO writes
//    still complete the handshake.
//  - CPU write: reg[waddr] <= wdata on posedge when we=1.
//  - io_ready = (reg[LOCK_REG]==0) && !(we && waddr==io_addr && io_addr!=0).
//    An IO write occurs on posedge when io_valid && io_ready.
//    The CPU port wins an address collision: io_ready=0, and the requester holds its request.
//    CPU and IO writes to different addresses both commit in the same cycle.
//  - Lock: an IO write to LOCK_REG with nonzero data takes effect and blocks later IO writes.
//    Unlock happens only via a CPU write of 0 or reset.
//  - Dump FSM: IDLE -> RUN on dump_start. RUN emits indices DUMP_FIRST..DUMP_LAST,
//    one per cycle, with dump_valid=1 (registered outputs).
//    First beat is the cycle after dump_start.
//    dump_data = register contents before the posedge on which that beat is registered.
//    A write landing in that same cycle is not visible in that beat.
//    After the last beat: DONE for 1 cycle (dump_done=1, dump_valid=0, dump_busy=0),
//    then IDLE.
//    dump_start in RUN/DONE is ignored.
//    Sweep length = DUMP_LAST-DUMP_FIRST+1 beats; dump_addr does not wrap past DUMP_LAST.
//  - Reads are combinational from raddr; same-cycle write behaviour is per CONFIGURATION.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: rdataN = wdata when we && waddr==raddrN && raddrN!=0.
//    This is CPU-port write-through; IO writes are never bypassed.
//  REGFILE_BYPASS_EN undefined: rdataN shows the old value until the posedge commits.
// TESTING
//  1. rst=1 mid-operation -> rdata1/2=0 for all addrs, dump_* = 0, io_ready=1.
//  2. we=1,waddr=0,wdata=32'hDEAD -> rdata1(raddr1=0)=0. we=1,waddr=5,wdata=32'h1234
//     -> rdata1=32'h1234 after posedge. Same cycle: 32'h1234 with REGFILE_BYPASS_EN, old value without.
//  3. Same cycle we=1,waddr=7,wdata=1 and io_valid,io_addr=7,io_data=2 -> io_ready=0, reg7=1.
//     Next cycle we=0 -> io_ready=1, reg7=2.
//  4. IO write reg31=32'h1 -> later io_valid,io_addr=4 gets io_ready=0 and reg4 unchanged.
//     CPU writes reg31=0 -> io_ready=1 again.
//  5. reg3..reg10 = 3..10, pulse dump_start -> 8 beats dump_addr 3..10, dump_data 3..10,
//     then dump_done for 1 cycle. Second dump_start during beat 4 has no effect.
//  6. rst asserted at beat 3 of a dump -> outputs 0 immediately, no dump_done.
//     A new dump_start after reset restarts at index 3.

Source files
------------

// File: rtl/regfile_param_dbg.sv
// regfile_param_dbg: GPR file with a lockable IO injection port and a register-window dump engine.
// Define REGFILE_BYPASS_EN to make the read ports show a same-cycle CPU write (write-through).
module regfile_param_dbg #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DUMP_FIRST = 3,
    parameter int DUMP_LAST  = 10,
    parameter int LOCK_REG   = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              io_valid,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_data,
    output logic              io_ready,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(DUMP_FIRST);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DUMP_LAST);
    localparam logic [ADDR_W-1:0] LOCK_A  = ADDR_W'(LOCK_REG);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] next_addr;
    logic              io_wr;
    logic              cpu_wr;

    // CPU port wins a same-address collision; the IO requester simply sees io_ready low
    assign io_ready  = (regs[LOCK_A] == '0) && !(we && waddr == io_addr && io_addr != '0);
    assign io_wr     = io_valid && io_ready && io_addr != '0;
    assign cpu_wr    = we && waddr != '0;
    assign next_addr = dump_addr + 1'b1;

`ifdef REGFILE_BYPASS_EN
    assign rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
`else
    assign rdata1 = raddr1 == '0 ? '0 : regs[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : regs[raddr2];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (io_wr) regs[io_addr] <= io_data;
            if (cpu_wr) regs[waddr] <= wdata;
        end
    end

    // Beats sample the pre-edge register contents, so a write in the same cycle is not seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dump_done <= 1'b0;
                    if (dump_start) begin
                        state      <= RUN;
                        dump_busy  <= 1'b1;
                        dump_valid <= 1'b1;
                        dump_addr  <= FIRST_A;
                        dump_data  <= regs[FIRST_A];
                    end
                end
                RUN: begin
                    if (dump_addr == LAST_A) begin
                        state      <= DONE;
                        dump_busy  <= 1'b0;
                        dump_valid <= 1'b0;
                        dump_done  <= 1'b1;
                    end else begin
                        dump_addr <= next_addr;
                        dump_data <= regs[next_addr];
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_param_dbg.sv
// tb_regfile_param_dbg: directed and random checks of regfile_param_dbg against an array/cycle-count model.
`timescale 1ns/1ps
module tb_regfile_param_dbg;
    localparam int N     = 8;
    localparam int FIRST = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, we, io_valid, dump_start;
    logic [4:0]  waddr, raddr1, raddr2, io_addr;
    logic [31:0] wdata, io_data;
    logic [31:0] rdata1, rdata2;
    logic        io_ready, dump_busy, dump_valid, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    logic [31:0] m [32];
    int          sw;
    int          cyc;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    regfile_param_dbg dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .io_valid(io_valid), .io_addr(io_addr), .io_data(io_data), .io_ready(io_ready),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return a == 5'd0 ? 32'd0 : (BYP && we && waddr == a) ? wdata : m[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        sw = -1;
    endtask

    // Entered just after a negedge with inputs set; returns at the next negedge
    task automatic cycle();
        logic        exp_rdy;
        logic        accept;
        logic        v;
        int          k;
        logic [31:0] pre [32];
        #1;
        exp_rdy = (m[31] == 32'd0) && !(we && waddr == io_addr && io_addr != 5'd0);
        chk("rdata1", rdata1, exp_rd(raddr1));
        chk("rdata2", rdata2, exp_rd(raddr2));
        chk("io_ready", 32'(io_ready), 32'(exp_rdy));
        pre = m;
        accept = !rst && dump_start && (sw < 0 || (cyc + 1) - sw >= N + 2);
        @(posedge clk);
        cyc++;
        if (rst) clear_model();
        else begin
            if (accept) sw = cyc;
            if (io_valid && exp_rdy && io_addr != 5'd0) m[io_addr] = io_data;
            if (we && waddr != 5'd0) m[waddr] = wdata;
        end
        #1;
        k = cyc - sw;
        v = sw >= 0 && k >= 0 && k < N;
        chk("dump_valid", 32'(dump_valid), 32'(v));
        chk("dump_busy", 32'(dump_busy), 32'(v));
        chk("dump_done", 32'(dump_done), 32'(sw >= 0 && k == N));
        if (v) begin
            chk("dump_addr", 32'(dump_addr), 32'(FIRST + k));
            chk("dump_data", dump_data, pre[5'(FIRST + k)]);
        end else if (sw < 0) begin
            chk("dump_addr_idle", 32'(dump_addr), 32'd0);
            chk("dump_data_idle", dump_data, 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; we = 1'b0; io_valid = 1'b0; dump_start = 1'b0;
        waddr = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0; io_addr = 5'd0;
        wdata = 32'd0; io_data = 32'd0;
        clear_model();
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Activity, then an asynchronous reset in the middle of a sweep
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5; io_valid = 1'b1; io_addr = 5'd12; io_data = 32'h77;
        cycle();
        we = 1'b0; io_valid = 1'b0; dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        clear_model();
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_busy", 32'(dump_busy), 32'd0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        chk("rst_dump_addr", 32'(dump_addr), 32'd0);
        chk("rst_dump_data", dump_data, 32'd0);
        chk("rst_io_ready", 32'(io_ready), 32'd1);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            chk("rst_rdata1", rdata1, 32'd0);
            chk("rst_rdata2", rdata2, 32'd0);
        end
        @(negedge clk);
        cycle();
        rst = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;

        // Writes to reg 0 are dropped; CPU write visibility
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD; raddr1 = 5'd0;
        cycle();
        chk("reg0_zero", rdata1, 32'd0);
        waddr = 5'd5; wdata = 32'h1234; raddr1 = 5'd5;
        #1;
        chk("same_cycle_rd", rdata1, BYP ? 32'h1234 : 32'd0);
        cycle();
        we = 1'b0;
        #1;
        chk("after_write", rdata1, 32'h1234);
        cycle();

        // Address collision: CPU wins, IO retries next cycle
        raddr1 = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'd1;
        io_valid = 1'b1; io_addr = 5'd7; io_data = 32'd2;
        #1;
        chk("collide_ready", 32'(io_ready), 32'd0);
        cycle();
        chk("collide_cpu", rdata1, 32'd1);
        we = 1'b0;
        #1;
        chk("retry_ready", 32'(io_ready), 32'd1);
        cycle();
        io_valid = 1'b0;
        #1;
        chk("retry_data", rdata1, 32'd2);
        cycle();

        // Lock via IO write to reg 31, unlock via CPU write of 0
        io_valid = 1'b1; io_addr = 5'd31; io_data = 32'd1;
        cycle();
        io_addr = 5'd4; io_data = 32'h55; raddr1 = 5'd4;
        #1;
        chk("locked_ready", 32'(io_ready), 32'd0);
        cycle();
        chk("locked_reg4", rdata1, 32'd0);
        we = 1'b1; waddr = 5'd31; wdata = 32'd0;
        cycle();
        we = 1'b0;
        #1;
        chk("unlocked_ready", 32'(io_ready), 32'd1);
        cycle();
        io_valid = 1'b0;
        #1;
        chk("unlocked_reg4", rdata1, 32'h55);
        cycle();

        // Full sweep with an ignored second start during the fourth beat
        for (int i = 3; i <= 10; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i);
            cycle();
        end
        we = 1'b0; dump_start = 1'b1;
        cycle();
        chk("beat_addr", 32'(dump_addr), 32'd3);
        chk("beat_data", dump_data, 32'd3);
        for (int k = 1; k < N; k++) begin
            dump_start = (k == 4);
            cycle();
            chk("beat_addr", 32'(dump_addr), 32'(3 + k));
            chk("beat_data", dump_data, 32'(3 + k));
        end
        dump_start = 1'b0;
        cycle();
        chk("done_pulse", 32'(dump_done), 32'd1);
        chk("done_valid", 32'(dump_valid), 32'd0);
        cycle();
        chk("done_clear", 32'(dump_done), 32'd0);

        // Reset during a sweep aborts it; a new start restarts at DUMP_FIRST
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        clear_model();
        chk("abort_valid", 32'(dump_valid), 32'd0);
        chk("abort_addr", 32'(dump_addr), 32'd0);
        chk("abort_data", dump_data, 32'd0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        dump_start = 1'b1;
        cycle();
        chk("restart_addr", 32'(dump_addr), 32'd3);
        chk("restart_valid", 32'(dump_valid), 32'd1);
        dump_start = 1'b0;

        // Random traffic against the model
        for (int t = 0; t < 600; t++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            if (waddr == 5'd31 && $urandom_range(0, 3) != 0) wdata = 32'd0;
            io_valid = 1'($urandom_range(0, 1));
            io_addr = $urandom_range(0, 3) == 0 ? waddr : 5'($urandom);
            io_data = $urandom_range(0, 4) == 0 ? 32'd0 : $urandom;
            raddr1 = $urandom_range(0, 3) == 0 ? waddr : 5'($urandom);
            raddr2 = $urandom_range(0, 3) == 0 ? io_addr : 5'($urandom_range(0, 12));
            dump_start = $urandom_range(0, 15) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
